axi_ddr_slv: RTL and testbench

AXI4 memory responder for the card-memory path: the slave end of the burst traffic that the CDMA read/write engines issue on `m_axi_ddr`. It serves INCR bursts from an on-chip simple-dual-port RAM, so CDMA, the TLB datapath and user logic can be built and verified without a DDR controller. Read and write channels are fully independent and each sustains one data beat per cycle.

---
 rtl/axi_ddr_slv_pkg.sv | 24 ++
 rtl/axi_ddr_slv_if.sv | 79 +++++++
 rtl/axi_ddr_slv_ram_sdp_be.sv | 33 +++
 rtl/axi_ddr_slv.sv | 291 +++++++++++++++++++++++++++++
 tb/tb_axi_ddr_slv.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_ddr_slv_pkg.sv
// Shared AXI response/burst codes and FSM state types for the DDR responder model.
package axi_ddr_slv_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_DATA = 2'd1,
        WR_RESP = 2'd2
    } wr_slv_state_t;

    typedef enum logic {
        RD_IDLE  = 1'b0,
        RD_BURST = 1'b1
    } rd_slv_state_t;

    // Map an accumulated error flag onto the AXI response code.
    function automatic logic [1:0] resp_of(input logic err);
        return err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
    endfunction

endpackage

// File: rtl/axi_ddr_slv_if.sv
// AXI4 bus (AW, W, B, AR, R) between a burst master and the DDR responder.
interface axi_ddr_slv_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 64,
    parameter int ID_BITS   = 6
);
    localparam int STRB_BITS = DATA_BITS / 8;

    logic [ID_BITS-1:0]   awid;
    logic [ADDR_BITS-1:0] awaddr;
    logic [7:0]           awlen;
    logic [2:0]           awsize;
    logic [1:0]           awburst;
    logic                 awlock;
    logic [3:0]           awcache;
    logic [2:0]           awprot;
    logic [3:0]           awqos;
    logic [3:0]           awregion;
    logic                 awvalid;
    logic                 awready;

    logic [DATA_BITS-1:0] wdata;
    logic [STRB_BITS-1:0] wstrb;
    logic                 wlast;
    logic                 wvalid;
    logic                 wready;

    logic [ID_BITS-1:0]   bid;
    logic [1:0]           bresp;
    logic                 bvalid;
    logic                 bready;

    logic [ID_BITS-1:0]   arid;
    logic [ADDR_BITS-1:0] araddr;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;
    logic [3:0]           arqos;
    logic [3:0]           arregion;
    logic                 arvalid;
    logic                 arready;

    logic [ID_BITS-1:0]   rid;
    logic [DATA_BITS-1:0] rdata;
    logic [1:0]           rresp;
    logic                 rlast;
    logic                 rvalid;
    logic                 rready;

    modport m (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport s (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awregion, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arregion, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );

endinterface

// File: rtl/axi_ddr_slv_ram_sdp_be.sv
// Simple dual-port RAM: byte-enabled write port, registered 1-cycle read port, read-first.
module ram_sdp_be #(
    parameter int DATA_BITS = 64,
    parameter int DEPTH     = 4096
) (
    input  logic                         aclk,
    input  logic                         we,
    input  logic [$clog2(DEPTH)-1:0]     waddr,
    input  logic [DATA_BITS/8-1:0]       wbe,
    input  logic [DATA_BITS-1:0]         wdata,
    input  logic                         re,
    input  logic [$clog2(DEPTH)-1:0]     raddr,
    output logic [DATA_BITS-1:0]         rdata
);
    localparam int NB = DATA_BITS / 8;

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Read samples the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge aclk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
        if (we) begin
            for (int b = 0; b < NB; b++) begin
                if (wbe[b]) begin
                    mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/axi_ddr_slv.sv
// AXI4 INCR-burst memory responder backed by on-chip RAM; independent read and write channels.
//
// Write FSM
//   state    | meaning
//   WR_IDLE  | awready high, waiting for an address
//   WR_DATA  | wready high, committing beats until the counter reaches awlen
//   WR_RESP  | bvalid high until bready
// Read FSM
//   state    | meaning
//   RD_IDLE  | arready high; the AR handshake also issues the first RAM read
//   RD_BURST | issuing reads into the 2-deep output FIFO, draining it onto R
module axi_ddr_slv
    import axi_ddr_slv_pkg::*;
#(
    parameter int DATA_BITS = 64,
    parameter int ADDR_BITS = 32,
    parameter int ID_BITS   = 6,
    parameter int MEM_DEPTH = 4096
) (
    input  logic      aclk,
    input  logic      areset,
    axi_ddr_slv_if.s  s_axi_ddr
);
    localparam int NB   = DATA_BITS / 8;
    localparam int OFFS = $clog2(NB);
    localparam int IDXW = $clog2(MEM_DEPTH);

    // ---------------------------------------------------------------- common
    logic live;

    // ready outputs stay low until the first edge after reset is released
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) live <= 1'b0;
        else        live <= 1'b1;
    end

    // ---------------------------------------------------------------- write side
    wr_slv_state_t        wr_state, wr_next;
    logic [ID_BITS-1:0]   w_id;
    logic [IDXW-1:0]      w_idx;
    logic [7:0]           w_len, w_cnt;
    logic                 w_berr, w_lerr;
    logic [1:0]           b_resp_q;
    logic                 aw_rdy, w_rdy, b_vld, ram_we;
    logic                 aw_hs, w_hs, b_hs, w_final, w_mis;

    assign aw_hs   = s_axi_ddr.awvalid & aw_rdy;
    assign w_hs    = s_axi_ddr.wvalid & w_rdy;
    assign b_hs    = b_vld & s_axi_ddr.bready;
    assign w_final = (w_cnt == w_len);
    assign w_mis   = (s_axi_ddr.wlast != w_final);

    // write FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) wr_state <= WR_IDLE;
        else        wr_state <= wr_next;
    end

    // write FSM next state and channel handshakes
    always_comb begin
        wr_next = wr_state;
        aw_rdy  = 1'b0;
        w_rdy   = 1'b0;
        b_vld   = 1'b0;
        ram_we  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                aw_rdy = live;
                if (live && s_axi_ddr.awvalid) wr_next = WR_DATA;
            end
            WR_DATA: begin
                w_rdy = 1'b1;
                if (s_axi_ddr.wvalid) begin
                    ram_we = ~w_berr;
                    if (w_final) wr_next = WR_RESP;
                end
            end
            WR_RESP: begin
                b_vld = 1'b1;
                if (s_axi_ddr.bready) wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    // write burst context: address index, beat count, error flags, response
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_id     <= '0;
            w_idx    <= '0;
            w_len    <= '0;
            w_cnt    <= '0;
            w_berr   <= 1'b0;
            w_lerr   <= 1'b0;
            b_resp_q <= AXI_RESP_OKAY;
        end else if (aw_hs) begin
            w_id   <= s_axi_ddr.awid;
            w_idx  <= s_axi_ddr.awaddr[OFFS +: IDXW];
            w_len  <= s_axi_ddr.awlen;
            w_cnt  <= '0;
            w_berr <= (s_axi_ddr.awburst != AXI_BURST_INCR);
            w_lerr <= 1'b0;
        end else if (w_hs) begin
            w_idx <= w_idx + 1'b1;
            w_cnt <= w_cnt + 8'd1;
            if (w_mis) w_lerr <= 1'b1;
            if (w_final) b_resp_q <= resp_of(w_berr | w_lerr | w_mis);
        end else if (b_hs) begin
            b_resp_q <= AXI_RESP_OKAY;
        end
    end

    assign s_axi_ddr.awready = aw_rdy;
    assign s_axi_ddr.wready  = w_rdy;
    assign s_axi_ddr.bvalid  = b_vld;
    assign s_axi_ddr.bid     = w_id;
    assign s_axi_ddr.bresp   = b_resp_q;

    // ---------------------------------------------------------------- read side
    rd_slv_state_t        rd_state, rd_next;
    logic [ID_BITS-1:0]   r_id;
    logic [IDXW-1:0]      r_idx, ram_raddr;
    logic [7:0]           r_len;
    logic [8:0]           r_iss;
    logic                 r_err;
    logic [1:0]           r_resp_q;
    logic                 ar_rdy, ar_hs, issue, issue_last, r_more;
    logic                 inflight, inf_last;
    logic [DATA_BITS-1:0] ram_q, push_data;
    logic [1:0]           occ, occ_n;
    logic [2:0]           eff;
    logic                 pop, push;
    logic [DATA_BITS-1:0] h_data, sp_data;
    logic                 h_last, sp_last, rvalid_q;

    assign ar_hs     = s_axi_ddr.arvalid & ar_rdy;
    assign pop       = rvalid_q & s_axi_ddr.rready;
    assign push      = inflight;
    assign push_data = r_err ? '0 : ram_q;
    assign r_more    = (r_iss <= {1'b0, r_len});
    // occupancy the FIFO will have once this cycle's in-flight read lands and any pop completes
    assign eff       = 3'(occ) + 3'(inflight) - 3'(pop);

    // read FSM state register
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) rd_state <= RD_IDLE;
        else        rd_state <= rd_next;
    end

    // read FSM next state, RAM read issue and flow control
    always_comb begin
        rd_next    = rd_state;
        ar_rdy     = 1'b0;
        issue      = 1'b0;
        issue_last = 1'b0;
        ram_raddr  = r_idx;
        case (rd_state)
            RD_IDLE: begin
                ar_rdy    = live;
                ram_raddr = s_axi_ddr.araddr[OFFS +: IDXW];
                if (live && s_axi_ddr.arvalid) begin
                    issue      = 1'b1;
                    issue_last = (s_axi_ddr.arlen == 8'd0);
                    rd_next    = RD_BURST;
                end
            end
            RD_BURST: begin
                if (r_more && (eff < 3'd2)) begin
                    issue      = 1'b1;
                    issue_last = (r_iss[7:0] == r_len);
                end
                if (pop && h_last) rd_next = RD_IDLE;
            end
            default: rd_next = RD_IDLE;
        endcase
    end

    // read burst context and in-flight tracking for the 1-cycle RAM latency
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_id     <= '0;
            r_idx    <= '0;
            r_len    <= '0;
            r_iss    <= '0;
            r_err    <= 1'b0;
            r_resp_q <= AXI_RESP_OKAY;
            inflight <= 1'b0;
            inf_last <= 1'b0;
        end else begin
            inflight <= issue;
            inf_last <= issue_last;
            if (ar_hs) begin
                r_id     <= s_axi_ddr.arid;
                r_idx    <= s_axi_ddr.araddr[OFFS +: IDXW] + 1'b1;
                r_len    <= s_axi_ddr.arlen;
                r_iss    <= 9'd1;
                r_err    <= (s_axi_ddr.arburst != AXI_BURST_INCR);
                r_resp_q <= resp_of(s_axi_ddr.arburst != AXI_BURST_INCR);
            end else if (issue) begin
                r_idx <= r_idx + 1'b1;
                r_iss <= r_iss + 9'd1;
            end
        end
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        occ_n = occ;
        case ({pop, push})
            2'b01:   occ_n = occ + 2'd1;
            2'b10:   occ_n = occ - 2'd1;
            default: occ_n = occ;
        endcase
    end

    // 2-entry output FIFO: head register drives R directly, spare absorbs one stalled beat
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            occ      <= '0;
            rvalid_q <= 1'b0;
            h_data   <= '0;
            h_last   <= 1'b0;
            sp_data  <= '0;
            sp_last  <= 1'b0;
        end else begin
            occ      <= occ_n;
            rvalid_q <= (occ_n != 2'd0);
            case ({pop, push})
                2'b01: begin
                    if (occ == 2'd0) begin
                        h_data <= push_data;
                        h_last <= inf_last;
                    end else begin
                        sp_data <= push_data;
                        sp_last <= inf_last;
                    end
                end
                2'b10: begin
                    if (occ == 2'd2) begin
                        h_data <= sp_data;
                        h_last <= sp_last;
                    end else begin
                        h_last <= 1'b0;
                    end
                end
                2'b11: begin
                    if (occ == 2'd2) begin
                        h_data  <= sp_data;
                        h_last  <= sp_last;
                        sp_data <= push_data;
                        sp_last <= inf_last;
                    end else begin
                        h_data <= push_data;
                        h_last <= inf_last;
                    end
                end
                default: ;
            endcase
        end
    end

    assign s_axi_ddr.arready = ar_rdy;
    assign s_axi_ddr.rvalid  = rvalid_q;
    assign s_axi_ddr.rdata   = h_data;
    assign s_axi_ddr.rlast   = h_last;
    assign s_axi_ddr.rid     = r_id;
    assign s_axi_ddr.rresp   = r_resp_q;

    // ---------------------------------------------------------------- storage
    ram_sdp_be #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (MEM_DEPTH)
    ) u_ram (
        .aclk  (aclk),
        .we    (ram_we),
        .waddr (w_idx),
        .wbe   (s_axi_ddr.wstrb),
        .wdata (s_axi_ddr.wdata),
        .re    (issue),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // attributes with no effect on a full-width on-chip memory, plus dropped address bits
    logic unused_ok;
    assign unused_ok = ^{s_axi_ddr.awsize, s_axi_ddr.awlock, s_axi_ddr.awcache, s_axi_ddr.awprot,
                         s_axi_ddr.awqos, s_axi_ddr.awregion, s_axi_ddr.awaddr,
                         s_axi_ddr.arsize, s_axi_ddr.arlock, s_axi_ddr.arcache, s_axi_ddr.arprot,
                         s_axi_ddr.arqos, s_axi_ddr.arregion, s_axi_ddr.araddr};

endmodule

// File: tb/tb_axi_ddr_slv.sv
// Directed + randomized bench for axi_ddr_slv against a flat-array memory model.
module tb_axi_ddr_slv;
    import axi_ddr_slv_pkg::*;

    localparam int DB    = 64;
    localparam int AB    = 32;
    localparam int IB    = 4;
    localparam int DEPTH = 4096;
    localparam int IDXW  = 12;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] mem_m [DEPTH];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];

    axi_ddr_slv_if #(.ADDR_BITS(AB), .DATA_BITS(DB), .ID_BITS(IB)) bus ();

    axi_ddr_slv #(
        .DATA_BITS (DB),
        .ADDR_BITS (AB),
        .ID_BITS   (IB),
        .MEM_DEPTH (DEPTH)
    ) dut (
        .aclk      (clk),
        .areset    (rst),
        .s_axi_ddr (bus)
    );

    // cycle index advances just before each falling edge, where all sampling happens
    initial forever begin
        #5 clk = 1'b1;
        #5 cyc++;
        clk = 1'b0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awready"}, 64'(bus.awready), 64'd0);
        chk({tag, "_wready"},  64'(bus.wready),  64'd0);
        chk({tag, "_bvalid"},  64'(bus.bvalid),  64'd0);
        chk({tag, "_arready"}, 64'(bus.arready), 64'd0);
        chk({tag, "_rvalid"},  64'(bus.rvalid),  64'd0);
        chk({tag, "_rlast"},   64'(bus.rlast),   64'd0);
        chk({tag, "_bresp"},   64'(bus.bresp),   64'd0);
        chk({tag, "_rresp"},   64'(bus.rresp),   64'd0);
    endtask

    function automatic int idx_of(input logic [31:0] addr);
        return int'(addr[3 +: IDXW]);
    endfunction

    // model: a write beat lands at (start index + beat) mod depth under its byte strobes
    function automatic void model_write(input int idx, input logic [63:0] d, input logic [7:0] s);
        for (int b = 0; b < 8; b++)
            if (s[b]) mem_m[idx % DEPTH][b*8 +: 8] = d[b*8 +: 8];
    endfunction

    task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                            input logic [IB-1:0] id, input int last_at, input int bdelay);
        int n;
        int idx;
        logic err;
        idx = idx_of(addr);
        err = (burst != 2'b01) || (last_at != len);
        bus.awid = id; bus.awaddr = addr; bus.awlen = len[7:0]; bus.awburst = burst;
        bus.awvalid = 1'b1;
        n = 0;
        while (!bus.awready && n < 50) begin @(negedge clk); n++; end
        chk("aw_accept", 64'(n < 50), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        chk("wready_T+1", 64'(bus.wready), 64'd1);
        for (int i = 0; i <= len; i++) begin
            bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = (i == last_at); bus.wvalid = 1'b1;
            n = 0;
            while (!bus.wready && n < 50) begin @(negedge clk); n++; end
            if (n >= 50) chk("w_accept", 64'd0, 64'd1);
            if (burst == 2'b01) model_write(idx + i, wd[i], ws[i]);
            @(negedge clk);
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        chk("bvalid_U+1", 64'(bus.bvalid), 64'd1);
        chk("wready_off", 64'(bus.wready), 64'd0);
        chk("bresp", 64'(bus.bresp), err ? 64'd2 : 64'd0);
        chk("bid", 64'(bus.bid), 64'(id));
        repeat (bdelay) @(negedge clk);
        if (bdelay > 0) chk("bvalid_hold", 64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk("awready_V+1", 64'(bus.awready), 64'd1);
        chk("bvalid_drop", 64'(bus.bvalid), 64'd0);
    endtask

    // mode 0: rready always high, 1: toggling, 2: random
    task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                           input logic [IB-1:0] id, input int mode);
        int n, t, beat, idx, first, tlast;
        logic [63:0] exp;
        idx = idx_of(addr);
        bus.arid = id; bus.araddr = addr; bus.arlen = len[7:0]; bus.arburst = burst;
        bus.arvalid = 1'b1;
        n = 0;
        while (!bus.arready && n < 50) begin @(negedge clk); n++; end
        chk("ar_accept", 64'(n < 50), 64'd1);
        t = cyc;
        @(negedge clk);
        bus.arvalid = 1'b0;
        beat = 0; first = -1; tlast = -1; n = 0;
        while (beat <= len && n < 600) begin
            case (mode)
                0:       bus.rready = 1'b1;
                1:       bus.rready = (n % 2 == 0);
                default: bus.rready = 1'($urandom_range(0, 1));
            endcase
            if (bus.rvalid && first < 0) first = cyc;
            if (bus.rvalid && bus.rready) begin
                exp = (burst == 2'b01) ? mem_m[(idx + beat) % DEPTH] : 64'd0;
                chk("rdata", bus.rdata, exp);
                chk("rlast", 64'(bus.rlast), 64'(beat == len));
                chk("rresp", 64'(bus.rresp), (burst == 2'b01) ? 64'd0 : 64'd2);
                chk("rid", 64'(bus.rid), 64'(id));
                if (beat == len) tlast = cyc;
                beat++;
            end
            @(negedge clk);
            n++;
        end
        bus.rready = 1'b0;
        chk("r_beats", 64'(beat), 64'(len + 1));
        chk("rvalid_T+2", 64'(first), 64'(t + 2));
        if (mode == 0) chk("rlast_T+2+len", 64'(tlast), 64'(t + 2 + len));
        chk("arready_V+1", 64'(bus.arready), 64'd1);
        chk("rvalid_drop", 64'(bus.rvalid), 64'd0);
    endtask

    logic [63:0] old_v, new_v;
    logic [31:0] ra;
    int          rl;

    initial begin
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = 3'd3; bus.awburst = 2'b01;
        bus.awlock = 1'b0; bus.awcache = '0; bus.awprot = '0; bus.awqos = '0; bus.awregion = '0;
        bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd3; bus.arburst = 2'b01;
        bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arqos = '0; bus.arregion = '0;
        bus.arvalid = 1'b0; bus.rready = 1'b0;
        for (int i = 0; i < DEPTH; i++) mem_m[i] = 'x;

        // reset state and ready rise
        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk("awready_after_reset", 64'(bus.awready), 64'd1);
        chk("arready_after_reset", 64'(bus.arready), 64'd1);

        // write 4 incrementing beats at 0x40, read them back
        for (int i = 0; i < 4; i++) begin wd[i] = 64'h1111_0000_0000_0000 + 64'(i); ws[i] = 8'hFF; end
        do_write(32'h40, 3, 2'b01, 4'h5, 3, 0);
        do_read(32'h40, 3, 2'b01, 4'h9, 0);

        // partial strobe: preload all ones, then clear only byte 0
        wd[0] = '1; ws[0] = 8'hFF;
        do_write(32'h80, 0, 2'b01, 4'h1, 0, 1);
        wd[0] = '0; ws[0] = 8'h01;
        do_write(32'h80, 0, 2'b01, 4'h2, 0, 0);
        do_read(32'h80, 0, 2'b01, 4'h3, 0);

        // wrap at the top of memory
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(32'((DEPTH - 2) * 8), 3, 2'b01, 4'h6, 3, 0);
        do_read(32'h0, 1, 2'b01, 4'h7, 0);
        do_read(32'((DEPTH - 2) * 8), 3, 2'b01, 4'h8, 1);

        // 16-beat read under toggling backpressure
        for (int i = 0; i < 16; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(32'h1000, 15, 2'b01, 4'hA, 15, 2);
        do_read(32'h1000, 15, 2'b01, 4'hB, 1);
        do_read(32'h1000, 15, 2'b01, 4'hC, 2);

        // error paths: FIXED write leaves memory alone, early wlast still commits, WRAP read is zeros
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(32'h40, 3, 2'b00, 4'hD, 3, 0);
        do_read(32'h40, 3, 2'b01, 4'hD, 0);
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(32'h400, 3, 2'b01, 4'hE, 1, 0);
        do_read(32'h400, 3, 2'b01, 4'hE, 0);
        do_read(32'h40, 3, 2'b10, 4'hF, 0);

        // read-first: write and read of one index handshake on the same edge
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        do_write(32'h200, 0, 2'b01, 4'h1, 0, 0);
        old_v = mem_m[idx_of(32'h200)];
        new_v = ~old_v;
        bus.awaddr = 32'h200; bus.awlen = 8'd0; bus.awburst = 2'b01; bus.awid = 4'h2; bus.awvalid = 1'b1;
        chk("rf_awready", 64'(bus.awready), 64'd1);
        @(negedge clk);
        bus.awvalid = 1'b0;
        bus.wdata = new_v; bus.wstrb = 8'hFF; bus.wlast = 1'b1; bus.wvalid = 1'b1;
        bus.araddr = 32'h200; bus.arlen = 8'd0; bus.arburst = 2'b01; bus.arid = 4'h3; bus.arvalid = 1'b1;
        bus.rready = 1'b1;
        chk("rf_wready", 64'(bus.wready), 64'd1);
        chk("rf_arready", 64'(bus.arready), 64'd1);
        @(negedge clk);
        bus.wvalid = 1'b0; bus.wlast = 1'b0; bus.arvalid = 1'b0;
        chk("rf_bvalid", 64'(bus.bvalid), 64'd1);
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        chk("rf_rvalid", 64'(bus.rvalid), 64'd1);
        chk("rf_rdata_old", bus.rdata, old_v);
        chk("rf_rlast", 64'(bus.rlast), 64'd1);
        @(negedge clk);
        bus.rready = 1'b0;
        mem_m[idx_of(32'h200)] = new_v;
        do_read(32'h200, 0, 2'b01, 4'h4, 0);

        // reset in the middle of a write burst and a stalled WRAP read
        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        bus.awaddr = 32'h3000; bus.awlen = 8'd3; bus.awburst = 2'b01; bus.awid = 4'h6; bus.awvalid = 1'b1;
        bus.araddr = 32'h40; bus.arlen = 8'd7; bus.arburst = 2'b10; bus.arid = 4'h7; bus.arvalid = 1'b1;
        @(negedge clk);
        bus.awvalid = 1'b0; bus.arvalid = 1'b0;
        bus.wdata = wd[0]; bus.wstrb = 8'hFF; bus.wlast = 1'b0; bus.wvalid = 1'b1;
        @(negedge clk);
        model_write(idx_of(32'h3000), wd[0], 8'hFF);
        bus.wdata = wd[1];
        @(negedge clk);
        model_write(idx_of(32'h3000) + 1, wd[1], 8'hFF);
        bus.wvalid = 1'b0;
        @(negedge clk);
        chk("mid_wready", 64'(bus.wready), 64'd1);
        chk("mid_rvalid", 64'(bus.rvalid), 64'd1);
        chk("mid_rresp", 64'(bus.rresp), 64'd2);
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_awready", 64'(bus.awready), 64'd1);
        chk("post_reset_arready", 64'(bus.arready), 64'd1);
        for (int i = 0; i < 2; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
        do_write(32'h3010, 1, 2'b01, 4'h8, 1, 0);
        do_read(32'h3000, 3, 2'b01, 4'h9, 0);

        // randomized bursts with aliased upper address bits and random strobes
        for (int k = 0; k < 8; k++) begin
            rl = int'($urandom_range(0, 7));
            ra = {17'($urandom), 12'($urandom), 3'b000};
            for (int i = 0; i <= rl; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
            do_write(ra, rl, 2'b01, 4'($urandom), rl, int'($urandom_range(0, 2)));
            for (int i = 0; i <= rl; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            do_write(ra ^ 32'hFFFF_8000, rl, 2'b01, 4'($urandom), rl, 0);
            do_read({17'($urandom), ra[14:0]}, rl, 2'b01, 4'($urandom), 2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
